// File: rtl/fpga_picobello_pkg.sv
// Shared AXI4 host-port payload types, default limits and isolation state enum
// for the FPGA-to-picobello host isolation gate.
package fpga_picobello_pkg;

    localparam int unsigned AxiAddrWidth = 32;
    localparam int unsigned AxiDataWidth = 32;
    localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;
    localparam int unsigned AxiIdWidth   = 4;

    localparam int unsigned FpgaMaxWrTxns = 8;
    localparam int unsigned FpgaMaxRdTxns = 8;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
    } axi_host_ax_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [AxiStrbWidth-1:0] strb;
        logic                    last;
    } axi_host_w_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0] id;
        logic [1:0]            resp;
    } axi_host_b_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } axi_host_r_t;

    typedef struct packed {
        axi_host_ax_t aw;
        logic         aw_valid;
        axi_host_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_host_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_host_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_host_b_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_host_r_t r;
        logic        r_valid;
    } axi_host_rsp_t;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } isolate_state_e;

endpackage

// File: rtl/fpga_axi_txn_counter.sv
// Saturating outstanding-transaction counter with a limit-reached flag.
module fpga_axi_txn_counter #(
    parameter int unsigned MaxTxns  = 8,
    parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                full_c
);

    logic [CntWidth-1:0] count_q;

    // Simultaneous inc/dec cancel; both ends saturate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && !dec_i && (count_q != CntWidth'(MaxTxns))) begin
            count_q <= count_q + CntWidth'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_q <= count_q - CntWidth'(1);
        end
    end

    // A response with nothing outstanding is a downstream protocol error.
    always_ff @(posedge clk_i) begin
        if (!rst_i && dec_i && !inc_i) begin
            assert (count_q != '0)
            else $error("fpga_axi_txn_counter: response with no outstanding transaction");
        end
    end

    assign count_o = count_q;
    assign full_c  = (count_q == CntWidth'(MaxTxns));

endmodule

// File: rtl/fpga_axi_host_isolate.sv
// AXI4 isolation gate between the FPGA host port and the picobello SoC: limits
// outstanding AW/AR, and on request drains in-flight traffic then reports isolation.
module fpga_axi_host_isolate
    import fpga_picobello_pkg::*;
#(
    parameter int unsigned MaxWrTxns     = FpgaMaxWrTxns,
    parameter int unsigned MaxRdTxns     = FpgaMaxRdTxns,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         axi_req_t     = axi_host_req_t,
    parameter type         axi_rsp_t     = axi_host_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               isolate_i,
    output logic                               isolated_o,
    output logic                               timeout_o,
    output logic [$clog2(MaxWrTxns + 1)-1:0]   wr_outstanding_o,
    output logic [$clog2(MaxRdTxns + 1)-1:0]   rd_outstanding_o,
    input  axi_req_t                           slv_req_i,
    output axi_rsp_t                           slv_rsp_o,
    output axi_req_t                           mst_req_o,
    input  axi_rsp_t                           mst_rsp_i
);

    localparam int unsigned WrCntWidth = $clog2(MaxWrTxns + 1);
    localparam int unsigned RdCntWidth = $clog2(MaxRdTxns + 1);
    localparam int unsigned TmrWidth   = $clog2(TimeoutCycles + 1);

    isolate_state_e      state_q, state_d;
    logic                aw_held_q, ar_held_q;
    logic [TmrWidth-1:0] timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic                isolated_q;

    logic                  wr_full, rd_full;
    logic [WrCntWidth-1:0] wr_count;
    logic [RdCntWidth-1:0] rd_count;
    logic                  aw_open, ar_open;
    logic                  mst_aw_valid, mst_ar_valid;
    logic                  aw_hs, ar_hs, b_hs, r_last_hs;
    logic                  drained;

    // A held request keeps its gate open so a presented valid is never withdrawn.
    assign aw_open = aw_held_q || ((state_q == NORMAL) && !wr_full);
    assign ar_open = ar_held_q || ((state_q == NORMAL) && !rd_full);

    assign mst_aw_valid = slv_req_i.aw_valid && aw_open;
    assign mst_ar_valid = slv_req_i.ar_valid && ar_open;

    assign aw_hs     = mst_aw_valid && mst_rsp_i.aw_ready;
    assign ar_hs     = mst_ar_valid && mst_rsp_i.ar_ready;
    assign b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;
    assign r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.ar_valid = mst_ar_valid;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_open;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_open;
    end

    fpga_axi_txn_counter #(
        .MaxTxns  (MaxWrTxns),
        .CntWidth (WrCntWidth)
    ) i_wr_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (aw_hs),
        .dec_i   (b_hs),
        .count_o (wr_count),
        .full_c  (wr_full)
    );

    fpga_axi_txn_counter #(
        .MaxTxns  (MaxRdTxns),
        .CntWidth (RdCntWidth)
    ) i_rd_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ar_hs),
        .dec_i   (r_last_hs),
        .count_o (rd_count),
        .full_c  (rd_full)
    );

    assign drained = (wr_count == '0) && (rd_count == '0) && !aw_held_q && !ar_held_q;

    // Next state plus drain timer; the timer only runs while staying in DRAIN.
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        timeout_d = 1'b0;
        case (state_q)
            NORMAL: begin
                if (isolate_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_d = NORMAL;
                end else if (drained) begin
                    state_d = ISOLATED;
                end else begin
                    timer_d   = (timer_q == TmrWidth'(TimeoutCycles)) ? timer_q
                                                                      : timer_q + TmrWidth'(1);
                    timeout_d = timeout_q || (timer_d == TmrWidth'(TimeoutCycles));
                end
            end
            ISOLATED: begin
                if (!isolate_i) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            isolated_q <= 1'b0;
            aw_held_q  <= 1'b0;
            ar_held_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            isolated_q <= (state_d == ISOLATED);
            if (aw_hs) aw_held_q <= 1'b0;
            else if (mst_aw_valid) aw_held_q <= 1'b1;
            if (ar_hs) ar_held_q <= 1'b0;
            else if (mst_ar_valid) ar_held_q <= 1'b1;
        end
    end

    assign isolated_o       = isolated_q;
    assign timeout_o        = timeout_q;
    assign wr_outstanding_o = wr_count;
    assign rd_outstanding_o = rd_count;

endmodule

// File: tb/tb_fpga_axi_host_isolate.sv
// Directed, table-driven bench for fpga_axi_host_isolate (limits 2/4, timeout 16).
module tb_fpga_axi_host_isolate;
    import fpga_picobello_pkg::*;

    localparam int unsigned MaxWr = 2;
    localparam int unsigned MaxRd = 4;
    localparam int unsigned Tmo   = 16;

    logic clk = 1'b0;
    logic rst;
    logic isolate;
    logic isolated, timeout;
    logic [$clog2(MaxWr + 1)-1:0] wr_out;
    logic [$clog2(MaxRd + 1)-1:0] rd_out;
    axi_host_req_t slv_req, mst_req;
    axi_host_rsp_t slv_rsp, mst_rsp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpga_axi_host_isolate #(
        .MaxWrTxns     (MaxWr),
        .MaxRdTxns     (MaxRd),
        .TimeoutCycles (Tmo),
        .axi_req_t     (axi_host_req_t),
        .axi_rsp_t     (axi_host_rsp_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .isolate_i        (isolate),
        .isolated_o       (isolated),
        .timeout_o        (timeout),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out),
        .slv_req_i        (slv_req),
        .slv_rsp_o        (slv_rsp),
        .mst_req_o        (mst_req),
        .mst_rsp_i        (mst_rsp)
    );

    // in:  {isolate, slv aw_valid, mst aw_ready, slv ar_valid, mst ar_ready, b_valid, r_valid, r_last}
    // ex:  {mst aw_valid, slv aw_ready, mst ar_valid, slv ar_ready}
    // fl:  {isolated, timeout}; wr/rd are the counts visible in that cycle
    typedef struct {
        logic [7:0] in;
        logic [3:0] ex;
        int         wr;
        int         rd;
        logic [1:0] fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [7:0] in, input logic [3:0] ex,
                                input int wr, input int rd, input logic [1:0] fl);
        vec_t v;
        v.in = in; v.ex = ex; v.wr = wr; v.rd = rd; v.fl = fl;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        isolate          = v[7];
        slv_req.aw_valid = v[6];
        mst_rsp.aw_ready = v[5];
        slv_req.ar_valid = v[4];
        mst_rsp.ar_ready = v[3];
        mst_rsp.b_valid  = v[2];
        mst_rsp.r_valid  = v[1];
        mst_rsp.r.last   = v[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slv_req = '0;
        mst_rsp = '0;
        slv_req.b_ready = 1'b1;
        slv_req.r_ready = 1'b1;
        isolate = 1'b0;
        rst     = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset.wr", 32'(wr_out), 0);
        chk("reset.rd", 32'(rd_out), 0);
        chk("reset.isolated", 32'(isolated), 0);
        chk("reset.timeout", 32'(timeout), 0);

        // Passthrough, limit back-pressure and simultaneous inc/dec
        add(8'b0_1_1_0_0_0_0_0, 4'b1100, 0, 0, 2'b00);
        add(8'b0_1_1_1_1_0_0_0, 4'b1111, 1, 0, 2'b00);
        add(8'b0_1_1_1_1_0_0_0, 4'b0011, 2, 1, 2'b00);
        add(8'b0_0_0_1_1_0_1_0, 4'b0011, 2, 2, 2'b00);
        add(8'b0_0_0_0_0_0_1_1, 4'b0000, 2, 3, 2'b00);
        add(8'b0_1_1_0_0_1_1_1, 4'b0000, 2, 2, 2'b00);
        add(8'b0_1_1_0_0_0_1_1, 4'b1100, 1, 1, 2'b00);
        add(8'b0_0_0_0_0_1_0_0, 4'b0000, 2, 0, 2'b00);
        add(8'b0_1_1_0_0_1_0_0, 4'b1100, 1, 0, 2'b00);
        add(8'b0_0_0_0_0_0_0_0, 4'b0000, 1, 0, 2'b00);
        add(8'b0_0_0_0_0_1_0_0, 4'b0000, 1, 0, 2'b00);
        add(8'b0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 2'b00);
        // Isolate with a stalled AW and one read outstanding
        add(8'b0_0_0_1_1_0_0_0, 4'b0011, 0, 0, 2'b00);
        add(8'b0_1_0_0_0_0_0_0, 4'b1000, 0, 1, 2'b00);
        add(8'b1_1_0_0_0_0_0_0, 4'b1000, 0, 1, 2'b00);
        add(8'b1_1_0_1_1_0_0_0, 4'b1000, 0, 1, 2'b00);
        add(8'b1_1_1_1_1_0_0_0, 4'b1100, 0, 1, 2'b00);
        add(8'b1_1_1_1_1_0_0_0, 4'b0000, 1, 1, 2'b00);
        add(8'b1_0_0_1_1_0_1_1, 4'b0000, 1, 1, 2'b00);
        add(8'b1_0_0_0_0_1_0_0, 4'b0000, 1, 0, 2'b00);
        add(8'b1_0_0_0_0_0_0_0, 4'b0000, 0, 0, 2'b00);
        add(8'b1_0_0_0_0_0_0_0, 4'b0000, 0, 0, 2'b10);
        add(8'b1_1_1_1_1_0_0_0, 4'b0000, 0, 0, 2'b10);
        add(8'b0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 2'b10);
        add(8'b0_0_0_0_0_0_0_0, 4'b0000, 0, 0, 2'b00);
        add(8'b0_1_1_0_0_0_0_0, 4'b1100, 0, 0, 2'b00);
        add(8'b0_0_0_0_0_1_0_0, 4'b0000, 1, 0, 2'b00);

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            slv_req.aw.addr = 32'h1000 + 32'(i) * 32'd16;
            mst_rsp.r.data  = 32'hC0DE_0000 | 32'(i);
            #1;
            chk($sformatf("v%0d.mst_aw_valid", i), 32'(mst_req.aw_valid), 32'(vecs[i].ex[3]));
            chk($sformatf("v%0d.slv_aw_ready", i), 32'(slv_rsp.aw_ready), 32'(vecs[i].ex[2]));
            chk($sformatf("v%0d.mst_ar_valid", i), 32'(mst_req.ar_valid), 32'(vecs[i].ex[1]));
            chk($sformatf("v%0d.slv_ar_ready", i), 32'(slv_rsp.ar_ready), 32'(vecs[i].ex[0]));
            chk($sformatf("v%0d.wr", i), 32'(wr_out), 32'(vecs[i].wr));
            chk($sformatf("v%0d.rd", i), 32'(rd_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d.isolated", i), 32'(isolated), 32'(vecs[i].fl[1]));
            chk($sformatf("v%0d.timeout", i), 32'(timeout), 32'(vecs[i].fl[0]));
            chk($sformatf("v%0d.aw_addr", i), mst_req.aw.addr, 32'h1000 + 32'(i) * 32'd16);
            chk($sformatf("v%0d.r_data", i), slv_rsp.r.data, 32'hC0DE_0000 | 32'(i));
            step();
        end

        // Drain timeout with a B that never returns
        drive(8'b0_1_1_0_0_0_0_0);
        step();
        drive(8'b1_0_0_0_0_0_0_0);
        step();
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 15 || k == 16 || k == 19) begin
                chk($sformatf("tmo.k%0d.timeout", k), 32'(timeout), (k >= 16) ? 1 : 0);
                chk($sformatf("tmo.k%0d.isolated", k), 32'(isolated), 0);
            end
        end
        chk("tmo.wr_held", 32'(wr_out), 1);
        drive(8'b0_0_0_0_0_0_0_0);
        step();
        chk("tmo.cleared", 32'(timeout), 0);
        drive(8'b0_1_0_0_0_0_0_0);
        #1;
        chk("tmo.normal_aw_valid", 32'(mst_req.aw_valid), 1);
        drive(8'b0_1_1_0_0_1_0_0);
        step();
        chk("tmo.wr_after_aw_b", 32'(wr_out), 1);
        drive(8'b0_0_0_0_0_1_0_0);
        step();
        chk("tmo.wr_final", 32'(wr_out), 0);

        // Reset in the middle of a timed-out drain with two writes outstanding
        drive(8'b0_1_1_0_0_0_0_0);
        step();
        step();
        drive(8'b1_0_0_0_0_0_0_0);
        step();
        repeat (17) step();
        chk("rst.pre_wr", 32'(wr_out), 2);
        chk("rst.pre_timeout", 32'(timeout), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.wr", 32'(wr_out), 0);
        chk("rst.rd", 32'(rd_out), 0);
        chk("rst.isolated", 32'(isolated), 0);
        chk("rst.timeout", 32'(timeout), 0);
        drive(8'b1_1_1_1_1_0_0_0);
        #1;
        chk("rst.normal_aw_ready", 32'(slv_rsp.aw_ready), 1);
        chk("rst.normal_ar_valid", 32'(mst_req.ar_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
